// File: rtl/instrn_fetch_if.sv
// Instruction fetch bus: the fetch unit's connections to the combinational-read
// instruction memory, the redirect request from the branch unit, and the
// valid/ready handshake toward the decode stage.
interface instrn_fetch_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_instrn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instrn;
    logic [31:0] id_pc;

    // Fetch unit side: drives the memory address and the decode-facing outputs
    modport fetch (
        output mem_addr,
        input  mem_instrn,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        input  id_ready,
        output id_instrn,
        output id_pc
    );

    // Environment side: memory, branch unit and decode stage
    modport env (
        input  mem_addr,
        output mem_instrn,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_instrn,
        input  id_pc
    );
endinterface

// File: rtl/instrn_fetch.sv
// Instruction fetch unit. Owns the PC and walks it through a small byte-addressed
// instruction memory, wrapping modulo MEM_BYTES. Each fetched word is captured
// with its PC into a 2-entry buffer whose head is offered to decode over a
// valid/ready handshake. A redirect flushes the buffer and restarts fetching at
// the target address.
// Optional feature: define INSTRN_FETCH_PERF_EN to add the perf_fetched and
// perf_stall saturating performance counters.
module instrn_fetch #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned MEM_BYTES = 20
) (
    input  logic          clk,
    input  logic          rst,
`ifdef INSTRN_FETCH_PERF_EN
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall,
`endif
    instrn_fetch_if.fetch bus
);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_FETCH,
        ST_FULL
    } state_t;

    localparam logic [31:0] MEM_SIZE = 32'(MEM_BYTES);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [1:0]  count_q;
    logic [31:0] buf_instrn [0:1];
    logic [31:0] buf_pc     [0:1];

    logic        pop;
    logic        push;
    logic [31:0] pc_inc;
    logic [31:0] pc_seq_next;
    logic [31:0] redirect_target;

    assign bus.mem_addr  = pc_q;
    assign bus.id_valid  = (count_q != 2'd0);
    assign bus.id_instrn = buf_instrn[0];
    assign bus.id_pc     = buf_pc[0];

    // Handshake decisions for this edge; a redirect suppresses the push and
    // the buffer flush swallows any pop that would otherwise occur.
    always_comb begin
        pop             = bus.id_valid && bus.id_ready;
        push            = !bus.redirect_valid && (state_q == ST_FETCH) &&
                          ((count_q < 2'd2) || pop);
        pc_inc          = pc_q + 32'd4;
        pc_seq_next     = (pc_inc < MEM_SIZE) ? pc_inc : (pc_inc - MEM_SIZE);
        redirect_target = (bus.redirect_pc % MEM_SIZE) & ~32'd3;
    end

    // Control FSM and program counter: WAIT idles one cycle after reset,
    // FETCH pushes a word per allowed edge, FULL holds until decode pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_WAIT;
            pc_q    <= RESET_PC;
        end else if (bus.redirect_valid) begin
            state_q <= ST_FETCH;
            pc_q    <= redirect_target;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (push) begin
                        pc_q <= pc_seq_next;
                    end
                    if (push && !pop && (count_q == 2'd1)) begin
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_WAIT;
                end
            endcase
        end
    end

    // Two-entry in-order buffer; entry 0 is the head seen by decode and keeps
    // its last contents when the buffer drains so id_instrn/id_pc hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q       <= 2'd0;
            buf_instrn[0] <= 32'd0;
            buf_instrn[1] <= 32'd0;
            buf_pc[0]     <= 32'd0;
            buf_pc[1]     <= 32'd0;
        end else if (bus.redirect_valid) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    buf_instrn[count_q[0]] <= bus.mem_instrn;
                    buf_pc[count_q[0]]     <= pc_q;
                    count_q                <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        buf_instrn[0] <= buf_instrn[1];
                        buf_pc[0]     <= buf_pc[1];
                    end
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        buf_instrn[0] <= bus.mem_instrn;
                        buf_pc[0]     <= pc_q;
                    end else begin
                        buf_instrn[0] <= buf_instrn[1];
                        buf_pc[0]     <= buf_pc[1];
                        buf_instrn[1] <= bus.mem_instrn;
                        buf_pc[1]     <= pc_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef INSTRN_FETCH_PERF_EN
    // Saturating counters: words pushed, and cycles stuck in FULL without a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (push && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if ((state_q == ST_FULL) && !pop && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instrn_fetch.sv
// Directed self-checking bench for instrn_fetch with a 20-byte big-endian
// instruction memory whose byte i holds 8'h10 + i.
module tb_instrn_fetch;

    logic clk;
    logic rst;
    int   check_count;
    int   pass_count;

    logic [7:0]  mem [0:19];
    logic [31:0] exp_word [0:4];

    instrn_fetch_if bus ();

`ifdef INSTRN_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    instrn_fetch #(
        .RESET_PC  (32'd0),
        .MEM_BYTES (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef INSTRN_FETCH_PERF_EN
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
`endif
        .bus          (bus.fetch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational big-endian instruction memory model
    always_comb begin
        if (bus.mem_addr <= 32'd16) begin
            bus.mem_instrn = {mem[bus.mem_addr[4:0]],
                              mem[bus.mem_addr[4:0] + 5'd1],
                              mem[bus.mem_addr[4:0] + 5'd2],
                              mem[bus.mem_addr[4:0] + 5'd3]};
        end else begin
            bus.mem_instrn = 32'hDEAD_BEEF;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic ready);
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.id_ready       = ready;
        #7;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.id_ready       = 1'b0;
        #3;
        check_count++;
        if (bus.mem_addr !== 32'd0) $display("[TB] FAIL reset_mem_addr: got %h expected %h", bus.mem_addr, 32'd0);
        else pass_count++;
        check_count++;
        if (bus.id_valid !== 1'b0) $display("[TB] FAIL reset_id_valid: got %b expected %b", bus.id_valid, 1'b0);
        else pass_count++;
        check_count++;
        if (bus.id_instrn !== 32'd0) $display("[TB] FAIL reset_id_instrn: got %h expected %h", bus.id_instrn, 32'd0);
        else pass_count++;
        check_count++;
        if (bus.id_pc !== 32'd0) $display("[TB] FAIL reset_id_pc: got %h expected %h", bus.id_pc, 32'd0);
        else pass_count++;
`ifdef INSTRN_FETCH_PERF_EN
        check_count++;
        if (perf_fetched !== 32'd0) $display("[TB] FAIL reset_perf_fetched: got %0d expected %0d", perf_fetched, 0);
        else pass_count++;
        check_count++;
        if (perf_stall !== 32'd0) $display("[TB] FAIL reset_perf_stall: got %0d expected %0d", perf_stall, 0);
        else pass_count++;
`endif
        @(negedge clk);
        rst = 1'b0;
        step();
        check_count++;
        if (bus.id_valid !== 1'b0) $display("[TB] FAIL wait_id_valid: got %b expected %b", bus.id_valid, 1'b0);
        else pass_count++;
        check_count++;
        if (bus.mem_addr !== 32'd0) $display("[TB] FAIL wait_mem_addr: got %h expected %h", bus.mem_addr, 32'd0);
        else pass_count++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [0:6];
        exp_pc = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd0, 32'd4};
        apply_reset(1'b1);
        step();
        check_count++;
        if (bus.id_valid !== 1'b0) $display("[TB] FAIL stream_first_edge_valid: got %b expected %b", bus.id_valid, 1'b0);
        else pass_count++;
        for (int i = 0; i < 7; i++) begin
            step();
            check_count++;
            if (bus.id_valid !== 1'b1) $display("[TB] FAIL stream_valid[%0d]: got %b expected %b", i, bus.id_valid, 1'b1);
            else pass_count++;
            check_count++;
            if (bus.id_pc !== exp_pc[i]) $display("[TB] FAIL stream_id_pc[%0d]: got %h expected %h", i, bus.id_pc, exp_pc[i]);
            else pass_count++;
            check_count++;
            if (bus.id_instrn !== exp_word[exp_pc[i] / 4]) $display("[TB] FAIL stream_id_instrn[%0d]: got %h expected %h", i, bus.id_instrn, exp_word[exp_pc[i] / 4]);
            else pass_count++;
        end
    endtask

    task automatic test_full_backpressure();
        logic [31:0] exp_pc [0:2];
        exp_pc = '{32'd4, 32'd8, 32'd12};
        apply_reset(1'b0);
        step();
        step();
        step();
        step();
        check_count++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd0) $display("[TB] FAIL full_head: got valid=%b pc=%h expected valid=1 pc=%h", bus.id_valid, bus.id_pc, 32'd0);
        else pass_count++;
        check_count++;
        if (bus.mem_addr !== 32'd8) $display("[TB] FAIL full_mem_addr_frozen: got %h expected %h", bus.mem_addr, 32'd8);
        else pass_count++;
        check_count++;
        if (bus.id_instrn !== exp_word[0]) $display("[TB] FAIL full_head_instrn: got %h expected %h", bus.id_instrn, exp_word[0]);
        else pass_count++;
        bus.id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_count++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== exp_pc[i]) $display("[TB] FAIL drain_id_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", i, bus.id_valid, bus.id_pc, exp_pc[i]);
            else pass_count++;
        end
    endtask

    task automatic test_redirect_full();
        logic [31:0] exp_pc [0:2];
        exp_pc = '{32'd12, 32'd16, 32'd0};
        apply_reset(1'b0);
        step();
        step();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd12;
        bus.id_ready       = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        check_count++;
        if (bus.id_valid !== 1'b0) $display("[TB] FAIL redirect_flush_valid: got %b expected %b", bus.id_valid, 1'b0);
        else pass_count++;
        check_count++;
        if (bus.mem_addr !== 32'd12) $display("[TB] FAIL redirect_mem_addr: got %h expected %h", bus.mem_addr, 32'd12);
        else pass_count++;
        for (int i = 0; i < 3; i++) begin
            step();
            check_count++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== exp_pc[i]) $display("[TB] FAIL redirect_id_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", i, bus.id_valid, bus.id_pc, exp_pc[i]);
            else pass_count++;
            check_count++;
            if (bus.id_instrn !== exp_word[exp_pc[i] / 4]) $display("[TB] FAIL redirect_id_instrn[%0d]: got %h expected %h", i, bus.id_instrn, exp_word[exp_pc[i] / 4]);
            else pass_count++;
        end
    endtask

    task automatic test_redirect_unaligned();
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd23;
        step();
        bus.redirect_valid = 1'b0;
        check_count++;
        if (bus.id_valid !== 1'b0) $display("[TB] FAIL unaligned_flush_valid: got %b expected %b", bus.id_valid, 1'b0);
        else pass_count++;
        check_count++;
        if (bus.mem_addr !== 32'd0) $display("[TB] FAIL unaligned_mem_addr: got %h expected %h", bus.mem_addr, 32'd0);
        else pass_count++;
        step();
        check_count++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd0) $display("[TB] FAIL unaligned_id_pc: got valid=%b pc=%h expected valid=1 pc=%h", bus.id_valid, bus.id_pc, 32'd0);
        else pass_count++;
    endtask

    task automatic test_redirect_wait();
        apply_reset(1'b1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd8;
        step();
        bus.redirect_valid = 1'b0;
        check_count++;
        if (bus.id_valid !== 1'b0 || bus.mem_addr !== 32'd8) $display("[TB] FAIL wait_redirect: got valid=%b addr=%h expected valid=0 addr=%h", bus.id_valid, bus.mem_addr, 32'd8);
        else pass_count++;
        step();
        check_count++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd8) $display("[TB] FAIL wait_redirect_id_pc: got valid=%b pc=%h expected valid=1 pc=%h", bus.id_valid, bus.id_pc, 32'd8);
        else pass_count++;
    endtask

    task automatic test_async_reset();
        apply_reset(1'b1);
        step();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check_count++;
        if (bus.id_valid !== 1'b0) $display("[TB] FAIL async_reset_valid: got %b expected %b", bus.id_valid, 1'b0);
        else pass_count++;
        check_count++;
        if (bus.mem_addr !== 32'd0) $display("[TB] FAIL async_reset_mem_addr: got %h expected %h", bus.mem_addr, 32'd0);
        else pass_count++;
        check_count++;
        if (bus.id_pc !== 32'd0 || bus.id_instrn !== 32'd0) $display("[TB] FAIL async_reset_head: got pc=%h instrn=%h expected pc=0 instrn=0", bus.id_pc, bus.id_instrn);
        else pass_count++;
        #1;
        rst = 1'b0;
        step();
        check_count++;
        if (bus.id_valid !== 1'b0 || bus.mem_addr !== 32'd0) $display("[TB] FAIL async_reset_wait: got valid=%b addr=%h expected valid=0 addr=0", bus.id_valid, bus.mem_addr);
        else pass_count++;
        step();
        check_count++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd0 || bus.mem_addr !== 32'd4) $display("[TB] FAIL async_reset_restart: got valid=%b pc=%h addr=%h expected valid=1 pc=0 addr=4", bus.id_valid, bus.id_pc, bus.mem_addr);
        else pass_count++;
    endtask

`ifdef INSTRN_FETCH_PERF_EN
    task automatic test_perf();
        apply_reset(1'b1);
        step();
        for (int i = 0; i < 4; i++) step();
        bus.id_ready = 1'b0;
        step();
        step();
        step();
        step();
        check_count++;
        if (perf_fetched !== 32'd5) $display("[TB] FAIL perf_fetched: got %0d expected %0d", perf_fetched, 5);
        else pass_count++;
        check_count++;
        if (perf_stall !== 32'd3) $display("[TB] FAIL perf_stall: got %0d expected %0d", perf_stall, 3);
        else pass_count++;
    endtask
`endif

    // Test sequence
    initial begin
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.id_ready       = 1'b0;
        check_count        = 0;
        pass_count         = 0;
        for (int i = 0; i < 20; i++) mem[i] = 8'(8'h10 + i);
        exp_word = '{32'h1011_1213, 32'h1415_1617, 32'h1819_1A1B,
                     32'h1C1D_1E1F, 32'h2021_2223};

        $display("[TB] starting instrn_fetch tests");
        test_reset();
        test_stream();
        test_full_backpressure();
        test_redirect_full();
        test_redirect_unaligned();
        test_redirect_wait();
        test_async_reset();
`ifdef INSTRN_FETCH_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
